mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage; sits directly upstream of the HI and LO registers.
- Executes MULT, MULTU, DIV, DIVU, MADD and MSUB over 32 iterations.
- Produces a 64-bit {HI,LO} result plus one-cycle write strobes that drive the HI/LO register enables.
- Busy output stalls the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is verified.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB; others reserved
- A  input  32  rs operand (multiplicand/dividend)
- B  input  32  rt operand (multiplier/divisor)
- HIin  input  32  current HI value, used by MADD/MSUB
- LOin  input  32  current LO value, used by MADD/MSUB
- HIout  output  32  result for HI (registered)
- LOout  output  32  result for LO (registered)
- HIen  output  1  HI write strobe
- LOen  output  1  LO write strobe
- Busy  output  1  operation in progress

Behaviour:
- Reset (Rst=1 at an edge):
  - State goes to IDLE.
  - HIout, LOout go to 0; HIen, LOen, Busy go to 0.
  - Iteration counter and internal registers are cleared.
  - Rst has priority over every other input. Reset mid-operation aborts with no strobe.
- States are IDLE, CALC and DONE.
- IDLE:
  - Start=1 with a valid Op at edge k latches A, B, Op, HIin, LOin.
  - Operands are converted to magnitudes for signed ops.
  - State goes to CALC with counter=0; Busy=1 from edge k.
  - A reserved Op with Start=1 is ignored: stays IDLE, no strobe.
- CALC:
  - One radix-2 step per edge at edges k+1..k+32. Multiply is shift-add; divide is restoring.
  - After step 32 (edge k+32), sign fixup and accumulate are applied.
  - At edge k+33, HIout/LOout are loaded and state goes to DONE.
- DONE:
  - HIen=LOen=1 for exactly one cycle, from edge k+33 to edge k+34.
  - At edge k+34: Busy=0, state returns to IDLE.
  - A new Start can be accepted at edge k+34 at the earliest.
- Start while Busy=1 is ignored. No queueing.
- HIout/LOout hold the last result indefinitely; they change only at edge k+33 or on reset.
- Multiply:
  - {HI,LO} is the 64-bit product.
  - MULT/MADD/MSUB are signed (two's complement); MULTU is unsigned.
- MADD: {HI,LO} = {HIin,LOin} + signed product, modulo 2^64.
- MSUB: {HI,LO} = {HIin,LOin} − signed product, modulo 2^64.
- Divide:
  - LO is the quotient, HI is the remainder.
  - DIV truncates toward zero; the remainder takes the dividend's sign.
  - DIVU is unsigned.
- Divide by zero (B=0), DIV or DIVU: LO=0xFFFFFFFF, HI=A. Normal latency and strobe apply.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No exception is raised.
- Latency is fixed at 34 cycles Start-to-idle for every op, including the special cases.

Decomposition:
- Shared package mdu_pkg holds:
  - Op encodings (OP_MULT..OP_MSUB).
  - State encodings (S_IDLE, S_CALC, S_DONE).
  - WIDTH=32 and the counter width constant.
- Sub-module mdu_shift_core: unsigned 32-step engine.
  - Modes are shift-add multiply and restoring divide.
  - Interface: load, step, and 64-bit state out.
- Top level owns the FSM, sign conversion, fixup, MADD/MSUB accumulate and special cases.

Test Plan:
- MULT A=0xFFFFFFFD (−3), B=7, Start at edge k → HIen/LOen high for exactly one cycle from edge k+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy low after edge k+34.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 → LO=0xFFFFFFFF, HI=0x00000007.
- DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- MADD HIin=0, LOin=0xFFFFFFFF, A=1, B=1 → HI=0x00000001, LO=0. MSUB HIin=0, LOin=0, A=1, B=1 → HI=LO=0xFFFFFFFF.
- DIVU started; second Start pulsed at k+5 → ignored, single strobe at k+33. Separate run: Rst at k+10 → Busy=0 next cycle, HIout=LOout=0, no strobe ever; next Start is accepted normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encodings, datapath width, iteration count and counter width, plus
// small helpers that classify an operation code.
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MSUB  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Codes 110 and 111 are reserved and never start an operation.
  function automatic logic op_valid(input logic [2:0] op);
    return op <= 3'b101;
  endfunction

  // Two's complement interpretation of the operands.
  function automatic logic op_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Request/result bundle between the EX stage and the multiply/divide unit.
//   Start, Op, A, B, HIin, LOin : request side (driven by the master)
//   HIout, LOout                : registered 64-bit result {HI,LO}
//   HIen, LOen                  : one-cycle HI/LO register write strobes
//   Busy                        : operation in flight, stalls the pipeline
// -----------------------------------------------------------------------------
interface mult_div_unit_if;
  import mdu_pkg::*;

  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HIin;
  logic [WIDTH-1:0] LOin;
  logic [WIDTH-1:0] HIout;
  logic [WIDTH-1:0] LOout;
  logic             HIen;
  logic             LOen;
  logic             Busy;

  modport master (
    output Start, Op, A, B, HIin, LOin,
    input  HIout, LOout, HIen, LOen, Busy
  );

  modport slave (
    input  Start, Op, A, B, HIin, LOin,
    output HIout, LOout, HIen, LOen, Busy
  );

endinterface

// File: rtl/mdu_shift_core.sv
// -----------------------------------------------------------------------------
// mdu_shift_core
// Unsigned radix-2 engine, one step per asserted step_i.
//   Clk, Rst   : clock, synchronous active-high reset
//   load_i     : capture a_i/b_i/div_i and clear the partial result
//   step_i     : perform one iteration
//   div_i      : 0 = shift-add multiply, 1 = restoring divide
//   a_i, b_i   : multiplicand/dividend and multiplier/divisor (unsigned)
//   state_o    : {hi,lo}; after WIDTH steps this is the product, or
//                {remainder, quotient} in divide mode
// -----------------------------------------------------------------------------
module mdu_shift_core #(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   sum;      // multiply: hi + addend with carry out
  logic [WIDTH:0]   rem_sh;   // divide: partial remainder shifted left by one
  logic [WIDTH:0]   diff;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    // The multiply operand sits in lo_q and is shifted out from the bottom
    // while product bits shift in from the top.
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide: hi_q is always below the divisor, so the shifted remainder is
    // below twice the divisor and a WIDTH+1 bit subtract cannot wrap.
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};

    if (load_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      div_d = div_i;
    end else if (step_i) begin
      if (!div_q) begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  assign state_o = {hi_q, lo_q};

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative MULT/MULTU/DIV/DIVU/MADD/MSUB unit feeding the HI/LO registers.
//   Clk, Rst : clock, synchronous active-high reset (aborts any operation)
//   bus      : mult_div_unit_if.slave - request operands and Op in,
//              registered {HIout,LOout}, one-cycle HIen/LOen, Busy out
// Timing from an accepted Start at edge k: iterations at k+1..k+32, result
// and strobes registered at k+33, back to IDLE (Busy low) at k+34. A new
// Start is accepted in IDLE, or in DONE at edge k+34 at the earliest.
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = mdu_pkg::WIDTH,
  parameter int ITER  = mdu_pkg::ITER
) (
  input  logic          Clk,
  input  logic          Rst,
  mult_div_unit_if.slave bus
);
  import mdu_pkg::*;

  localparam int CW = $clog2(ITER + 1);
  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hiin_q, hiin_d;
  logic [WIDTH-1:0] loin_q, loin_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;

  op_e              op_in;
  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             core_load, core_step;
  logic [W2-1:0]    core_state;

  logic             sa, sb;
  logic [W2-1:0]    prod, acc, result;
  logic [WIDTH-1:0] quo, rem;

  assign op_in  = op_e'(bus.Op);
  assign accept = bus.Start && op_valid(bus.Op);
  // The core is unsigned; signed operands enter as magnitudes and the sign
  // is restored after the last iteration. -0x80000000 is its own magnitude.
  assign a_mag  = (op_signed(op_in) && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_mag  = (op_signed(op_in) && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  mdu_shift_core #(.WIDTH(WIDTH)) u_core (
    .Clk     (Clk),
    .Rst     (Rst),
    .load_i  (core_load),
    .step_i  (core_step),
    .div_i   (op_is_div(op_in)),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .state_o (core_state)
  );

  // Sign fixup, accumulate and divide-by-zero override on the finished core
  // state. Divide by zero bypasses the core because a sign-corrected all-ones
  // quotient would not give the architected 0xFFFFFFFF.
  always_comb begin
    sa   = op_signed(op_q) && a_q[WIDTH-1];
    sb   = op_signed(op_q) && b_q[WIDTH-1];
    prod = (sa ^ sb) ? -core_state : core_state;
    acc  = {hiin_q, loin_q};
    quo  = core_state[WIDTH-1:0];
    rem  = core_state[W2-1:WIDTH];
    if (sa ^ sb) quo = -quo;
    if (sa)      rem = -rem;   // remainder follows the dividend's sign
    case (op_q)
      OP_MADD:         result = acc + prod;
      OP_MSUB:         result = acc - prod;
      OP_DIV, OP_DIVU: result = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
      default:         result = prod;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hiin_d    = hiin_q;
    loin_d    = loin_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    en_d      = 1'b0;
    busy_d    = busy_q;
    core_load = 1'b0;
    core_step = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        if (accept) begin
          state_d   = S_CALC;
          busy_d    = 1'b1;
          cnt_d     = '0;
          op_d      = op_in;
          a_d       = bus.A;
          b_d       = bus.B;
          hiin_d    = bus.HIin;
          loin_d    = bus.LOin;
          core_load = 1'b1;
        end
      end
      S_CALC: begin
        if (cnt_q < CW'(ITER)) begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end else begin
          hi_d    = result[W2-1:WIDTH];
          lo_d    = result[WIDTH-1:0];
          en_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hiin_q  <= '0;
      loin_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hiin_q  <= hiin_d;
      loin_q  <= loin_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.HIout = hi_q;
  assign bus.LOout = lo_q;
  assign bus.HIen  = en_q;
  assign bus.LOen  = en_q;
  assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed, table-driven bench for mult_div_unit with hand-computed results,
// plus sequences for ignored Start, reserved Op, mid-operation reset and a
// back-to-back start accepted in the DONE cycle.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_unit_if bus();

  mult_div_unit dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hiin;
    logic [31:0] loin;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] op, input logic [31:0] a, b, hiin, loin,
                         input logic [31:0] eh, el, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hiin = hiin; v.loin = loin;
    v.exp_hi = eh; v.exp_lo = el; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; Start is sampled at the next edge (edge k) and
  // the task returns #1 after edge k.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, hiin, loin);
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.HIin  = hiin;
    bus.LOin  = loin;
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
  endtask

  // Entered #1 after edge k; returns #1 after edge k+33 with the strobe cycle
  // checked. inject_at > 0 pulses a competing MULTU Start sampled at k+inject_at.
  task automatic watch(input string name, input logic [31:0] eh, input logic [31:0] el,
                       input int inject_at);
    int stray;
    stray = 0;
    check({name, " busy@k"}, {31'd0, bus.Busy}, 32'd1);
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk); #1;
      if (inject_at > 0 && i == inject_at) bus.Start = 1'b0;
      if (i < 33) begin
        if (bus.HIen || bus.LOen || !bus.Busy) stray++;
        if (inject_at > 0 && i == inject_at - 1) begin
          bus.Op = 3'b001; bus.A = 32'd3; bus.B = 32'd3; bus.Start = 1'b1;
        end
      end
    end
    check({name, " early strobe/busy drop"}, stray, 0);
    check({name, " HIen@k+33"}, {31'd0, bus.HIen}, 32'd1);
    check({name, " LOen@k+33"}, {31'd0, bus.LOen}, 32'd1);
    check({name, " HI"}, bus.HIout, eh);
    check({name, " LO"}, bus.LOout, el);
  endtask

  // From #1 after edge k+33: strobe gone and Busy low after edge k+34.
  task automatic finish_op(input string name);
    @(posedge clk); #1;
    check({name, " busy@k+34"}, {31'd0, bus.Busy}, 32'd0);
    check({name, " strobe@k+34"}, {30'd0, bus.HIen, bus.LOen}, 32'd0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int stray;
    stray = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.HIen || bus.LOen || bus.Busy) stray++;
    end
    check({name, " quiet cycles with strobe/busy"}, stray, 0);
  endtask

  initial begin
    logic [31:0] last_hi, last_lo;

    add_vec(3'b000, 32'hFFFFFFFD, 32'd7,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB, "MULT -3*7");
    add_vec(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        32'hFFFFFFFE, 32'h00000001, "MULTU max*max");
    add_vec(3'b010, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, "DIV -7/2");
    add_vec(3'b011, 32'd7,        32'd0,        32'd0, 32'd0,        32'h00000007, 32'hFFFFFFFF, "DIVU 7/0");
    add_vec(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,        32'h00000000, 32'h80000000, "DIV min/-1");
    add_vec(3'b100, 32'd1,        32'd1,        32'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, "MADD carry");
    add_vec(3'b101, 32'd1,        32'd1,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, "MSUB borrow");
    add_vec(3'b011, 32'd100,      32'd7,        32'd0, 32'd0,        32'h00000002, 32'h0000000E, "DIVU 100/7");
    add_vec(3'b010, 32'd7,        32'hFFFFFFFE, 32'd0, 32'd0,        32'h00000001, 32'hFFFFFFFD, "DIV 7/-2");
    add_vec(3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd0, 32'd0,        32'hFFFFFFFF, 32'h00000003, "DIV -7/-2");
    add_vec(3'b010, 32'hFFFFFFFB, 32'd0,        32'd0, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "DIV -5/0");
    add_vec(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        32'h00000000, 32'h00000001, "MULT -1*-1");
    add_vec(3'b001, 32'h80000000, 32'd2,        32'd0, 32'd0,        32'h00000001, 32'h00000000, "MULTU 2^31*2");
    add_vec(3'b100, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd10,       32'h00000000, 32'h00000004, "MADD 10+(-2*3)");
    add_vec(3'b101, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd0,        32'h00000000, 32'h00000006, "MSUB 0-(-2*3)");
    add_vec(3'b100, 32'hFFFFFFFF, 32'd1,        32'd1, 32'd0,        32'h00000000, 32'hFFFFFFFF, "MADD 2^32+(-1)");

    bus.Start = 1'b0; bus.Op = 3'b000; bus.A = '0; bus.B = '0; bus.HIin = '0; bus.LOin = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset HIout", bus.HIout, 32'd0);
    check("reset LOout", bus.LOout, 32'd0);
    check("reset strobes", {30'd0, bus.HIen, bus.LOen}, 32'd0);
    check("reset Busy", {31'd0, bus.Busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hiin, vecs[i].loin);
      watch(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo, 0);
      finish_op(vecs[i].name);
      $display("vector %0d %s: HI=0x%08h LO=0x%08h", i, vecs[i].name, bus.HIout, bus.LOout);
    end
    last_hi = vecs[vecs.size()-1].exp_hi;
    last_lo = vecs[vecs.size()-1].exp_lo;

    // Reserved Op is ignored and the previous result is held.
    issue(3'b110, 32'd5, 32'd5, 32'd0, 32'd0);
    check("reserved busy", {31'd0, bus.Busy}, 32'd0);
    quiet("reserved", 40);
    check("hold HI", bus.HIout, last_hi);
    check("hold LO", bus.LOout, last_lo);
    $display("reserved op: Busy=%0b HI=0x%08h LO=0x%08h", bus.Busy, bus.HIout, bus.LOout);

    // Second Start at k+5 while busy is ignored: single DIVU result.
    issue(3'b011, 32'd100, 32'd7, 32'd0, 32'd0);
    watch("ignored start", 32'h00000002, 32'h0000000E, 5);
    finish_op("ignored start");
    quiet("ignored start tail", 40);
    $display("ignored start: HI=0x%08h LO=0x%08h", bus.HIout, bus.LOout);

    // Reset at k+10 aborts without a strobe.
    issue(3'b000, 32'd5, 32'd6, 32'd0, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort Busy", {31'd0, bus.Busy}, 32'd0);
    check("abort HIout", bus.HIout, 32'd0);
    check("abort LOout", bus.LOout, 32'd0);
    quiet("abort", 40);
    issue(3'b000, 32'd5, 32'd6, 32'd0, 32'd0);
    watch("after abort", 32'd0, 32'd30, 0);
    finish_op("after abort");
    $display("reset abort: HI=0x%08h LO=0x%08h", bus.HIout, bus.LOout);

    // Start presented during the DONE cycle is accepted at edge k+34.
    issue(3'b001, 32'd3, 32'd4, 32'd0, 32'd0);
    watch("b2b first", 32'd0, 32'd12, 0);
    bus.Op = 3'b011; bus.A = 32'd50; bus.B = 32'd8; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    watch("b2b second", 32'd2, 32'd6, 0);
    finish_op("b2b second");
    $display("back-to-back: HI=0x%08h LO=0x%08h", bus.HIout, bus.LOout);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
